z80_bus_cycle_ctrl: RTL
=======================

// Module: z80_bus_cycle_ctrl
// PURPOSE
//  Bus-side companion of the T80a CPU wrapper. Generates the CPU clock enable (turbo-selectable)
//  and turns raw Z80 strobes (mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n) into one req/ack handshake per
//  bus cycle toward a memory port and an I/O port. Holds wait_n low until the device acks and
//  registers read data onto the CPU di bus. Sits between the CPU wrapper and the memory/ULA/IO fabric.
// PARAMETERS
//  TIMEOUT    64     sys clocks from req to forced completion (no ack); must be >= 2
//  INTACK_VEC 8'hFF  data returned on interrupt-acknowledge (m1_n & iorq_n low), no device req
//  FLOAT_BYTE 8'hFF  data returned on timeout
// PORTS
//  clk        in   1   system clock (28 MHz)
//  rst        in   1   synchronous reset, active high
//  turbo      in   2   0:/8 (3.5MHz) 1:/4 2:/2 3:/1
//  cpu_cen    out  1   one-clk-wide clock enable to CPU (clk_enable)
//  cpu_wait_n out  1   to CPU wait_n
//  cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n  in 1 each, from CPU
//  cpu_a      in   16  CPU address
//  cpu_dout   in   8   CPU write data
//  cpu_di     out  8   CPU read data
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   1=write; valid with mem_req
//  mem_ack    in   1   one-clk completion; mem_rdata valid same clk
//  mem_rdata  in   8
//  io_req, io_we, io_ack, io_rdata   same as mem_* for I/O space
//  bus_addr   out  16  address latched at cycle start, shared by both ports
//  bus_wdata  out  8   write data latched at cycle start
//  bus_err    out  1   one-clk pulse on timeout
// BEHAVIOUR
//  Reset: cpu_cen=0, cpu_wait_n=1, cpu_di=8'hFF, mem_req=io_req=0, *_we=0, bus_addr=0,
//   bus_wdata=0, bus_err=0, divider=0, state IDLE.
//  Divider: 3-bit counter; cpu_cen=1 when count==0 (masked per turbo: /8 all 3 bits, /4 low 2,
//   /2 low 1, /1 always). turbo sampled only when counter==0 (glitch-free change).
//  CPU strobes used as registered (1 clk) copies. Cycle types decoded in IDLE:
//   MEM  = !mreq_n & rfsh_n & (!rd_n | !wr_n)       (refresh cycles ignored)
//   IO   = !iorq_n & m1_n & (!rd_n | !wr_n)
//   IACK = !iorq_n & !m1_n
//  FSM: IDLE -> MEMREQ (MEM) | IOREQ (IO) | DONE (IACK: cpu_di<=INTACK_VEC).
//   Entry latches bus_addr=cpu_a, bus_wdata=cpu_dout, *_we=!wr_n; req rises next clk (1-clk latency).
//   MEMREQ/IOREQ: cpu_wait_n=0; on ack: req=0, read-> cpu_di<=rdata, -> DONE.
//   Timeout counter reaching TIMEOUT: req=0, cpu_di<=FLOAT_BYTE, bus_err=1 for 1 clk, -> DONE.
//   DONE: cpu_wait_n=1; stay until registered mreq_n & iorq_n both high, then -> IDLE.
//  cpu_wait_n low is combinational from state (not cen-gated); CPU samples it on its cen.
//  Priority if MEM and IO both decode (illegal on Z80): MEM.
//  ack arriving same clk as timeout: ack wins, no bus_err.
//  ack while not in REQ state: ignored. cpu_di holds last value outside completions.
//  Reset mid-cycle: all outputs to reset values next clk; CPU cycle in progress not completed.
//  Write data and address stable from req rise through ack.
// STRUCTURE
//  Shared package: cycle-type encoding, FSM state constants, turbo encoding constants.
//  One sub-module natural: z80_cen_divider (turbo divider + cpu_cen); FSM stays in top.
// TESTING
//  turbo=0 reset release -> cpu_cen pulses every 8 clks; switch to 3 mid-period -> change at next wrap, then every clk.
//  MEM read A=16'h4000, mem_ack after 3 clks with 8'hA5 -> mem_req 1 clk after decode, wait_n low until ack, cpu_di=8'hA5.
//  IO write A=16'h00FE, cpu_dout=8'h07 -> io_req, io_we=1, bus_wdata=8'h07, bus_addr=16'h00FE, mem_req stays 0.
//  IACK (m1_n=0, iorq_n=0) -> no req, cpu_di=8'hFF, wait_n never low.
//  MEM read, no ack -> after 64 clks req drops, bus_err 1-clk pulse, cpu_di=8'hFF; refresh cycle (rfsh_n=0) -> no req.
//  rst asserted while mem_req=1 -> next clk mem_req=0, wait_n=1, state IDLE.

Source files
------------

// File: rtl/z80_bus_cycle_ctrl_pkg.sv
// Shared types and constants for the Z80 bus-cycle controller.
package z80_bus_cycle_ctrl_pkg;

  localparam int unsigned DIV_W = 3;

  // Cycle type decoded from the registered CPU strobes
  typedef enum logic [1:0] {
    CYC_NONE = 2'd0,
    CYC_MEM  = 2'd1,
    CYC_IO   = 2'd2,
    CYC_IACK = 2'd3
  } cycle_t;

  // Bus FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MEMREQ = 2'd1;
  localparam logic [1:0] ST_IOREQ  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Turbo select encoding
  localparam logic [1:0] TURBO_DIV8 = 2'd0;
  localparam logic [1:0] TURBO_DIV4 = 2'd1;
  localparam logic [1:0] TURBO_DIV2 = 2'd2;
  localparam logic [1:0] TURBO_DIV1 = 2'd3;

  // Registered copy of the raw Z80 control strobes (all active low)
  typedef struct packed {
    logic m1_n;
    logic mreq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic rfsh_n;
  } cpu_strobes_t;

  // Divider count bits that must be zero for a CPU clock enable
  function automatic logic [DIV_W-1:0] turbo_mask(input logic [1:0] turbo);
    logic [DIV_W-1:0] m;
    case (turbo)
      TURBO_DIV8: m = 3'b111;
      TURBO_DIV4: m = 3'b011;
      TURBO_DIV2: m = 3'b001;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

  // Memory wins if both spaces decode; refresh cycles never reach memory
  function automatic cycle_t decode_cycle(input cpu_strobes_t s);
    cycle_t c;
    c = CYC_NONE;
    if (!s.mreq_n && s.rfsh_n && (!s.rd_n || !s.wr_n))
      c = CYC_MEM;
    else if (!s.iorq_n && s.m1_n && (!s.rd_n || !s.wr_n))
      c = CYC_IO;
    else if (!s.iorq_n && !s.m1_n)
      c = CYC_IACK;
    return c;
  endfunction

endpackage

// File: rtl/z80_bus_cycle_ctrl_cen.sv
// Turbo-selectable CPU clock-enable divider.
module z80_cen_divider
  import z80_bus_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] turbo,
  output logic       cpu_cen
);

  logic [DIV_W-1:0] cnt_q;
  logic [1:0]       turbo_q;

  // Free-running count; turbo only re-sampled at wrap so the enable never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      turbo_q <= TURBO_DIV8;
      cpu_cen <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
      cpu_cen <= (cnt_q & turbo_mask(turbo_q)) == '0;
      if (cnt_q == '0)
        turbo_q <= turbo;
    end
  end

endmodule

// File: rtl/z80_bus_cycle_ctrl.sv
// Converts Z80 bus strobes into one req/ack handshake per cycle on memory or I/O.
module z80_bus_cycle_ctrl
  import z80_bus_cycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [7:0]  INTACK_VEC = 8'hFF,
  parameter logic [7:0]  FLOAT_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  turbo,
  output logic        cpu_cen,
  output logic        cpu_wait_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        io_req,
  output logic        io_we,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  cpu_strobes_t     stb_q;
  cycle_t           cyc_c;
  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_req_d, mem_we_d, io_req_d, io_we_d, bus_err_d;
  logic [15:0]      bus_addr_d;
  logic [7:0]       bus_wdata_d, cpu_di_d;
  logic             ack_c, we_c, tmo_hit_c;
  logic [7:0]       rdata_c;

  z80_cen_divider u_cen (
    .clk     (clk),
    .rst     (rst),
    .turbo   (turbo),
    .cpu_cen (cpu_cen)
  );

  // One-clock registered copy of the CPU strobes
  always_ff @(posedge clk) begin
    if (rst)
      stb_q <= '1;
    else
      stb_q <= '{m1_n: cpu_m1_n, mreq_n: cpu_mreq_n, iorq_n: cpu_iorq_n,
                 rd_n: cpu_rd_n, wr_n: cpu_wr_n, rfsh_n: cpu_rfsh_n};
  end

  assign cyc_c      = decode_cycle(stb_q);
  assign cpu_wait_n = !((state_q == ST_MEMREQ) || (state_q == ST_IOREQ));
  assign ack_c      = (state_q == ST_MEMREQ) ? mem_ack   : io_ack;
  assign rdata_c    = (state_q == ST_MEMREQ) ? mem_rdata : io_rdata;
  assign we_c       = (state_q == ST_MEMREQ) ? mem_we    : io_we;
  assign tmo_hit_c  = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Next-state and next-output logic for the bus cycle FSM
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    io_req_d    = io_req;
    io_we_d     = io_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    cpu_di_d    = cpu_di;
    bus_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        case (cyc_c)
          CYC_MEM: begin
            state_d     = ST_MEMREQ;
            mem_req_d   = 1'b1;
            mem_we_d    = !stb_q.wr_n;
            bus_addr_d  = cpu_a;
            bus_wdata_d = cpu_dout;
          end
          CYC_IO: begin
            state_d     = ST_IOREQ;
            io_req_d    = 1'b1;
            io_we_d     = !stb_q.wr_n;
            bus_addr_d  = cpu_a;
            bus_wdata_d = cpu_dout;
          end
          CYC_IACK: begin
            state_d  = ST_DONE;
            cpu_di_d = INTACK_VEC;
          end
          default: ;
        endcase
      end
      ST_MEMREQ, ST_IOREQ: begin
        // ack is checked first so a same-clock ack beats the timeout
        if (ack_c || tmo_hit_c) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          io_req_d  = 1'b0;
          io_we_d   = 1'b0;
          if (ack_c) begin
            if (!we_c)
              cpu_di_d = rdata_c;
          end else begin
            cpu_di_d  = FLOAT_BYTE;
            bus_err_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        if (stb_q.mreq_n && stb_q.iorq_n)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_di    <= 8'hFF;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      io_req    <= io_req_d;
      io_we     <= io_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      cpu_di    <= cpu_di_d;
      bus_err   <= bus_err_d;
    end
  end

endmodule
